// File: rtl/harris_pkg.sv
// Shared types for the Harris neighbour sequencer: default widths, FSM states, pair order.
// Latency: n/a (types only).
// Backpressure: n/a.
package harris_pkg;

    localparam int PIX_W_DEF = 8;
    localparam int E_W_DEF   = 14;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP,
        DONE
    } seq_state_t;

    // Pair index k maps to the neighbour in this order.
    typedef enum logic [2:0] {
        NW,
        N,
        NE,
        W,
        E,
        SW,
        S,
        SE
    } nbr_t;

endpackage

// File: rtl/harris_line_buffer.sv
// One image line of pixels, addressed by column; old value read out as the new one is written.
// Latency: read is combinational, write lands at the clock edge.
// Backpressure: none; writes only when en is high.
module harris_line_buffer #(
    parameter int IMG_W = 64,
    parameter int PIX_W = 8,
    parameter int CW    = $clog2(IMG_W)
) (
    input  logic             clk,
    input  logic             en,
    input  logic [CW-1:0]    col,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] dout
);

    logic [PIX_W-1:0] mem [IMG_W];

    assign dout = mem[col];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[col] <= din;
        end
    end

endmodule

// File: rtl/harris_neighbor_sequencer.sv
// Raster intake into a 3x3 window; issues the 8 (center, neighbour) pairs per interior pixel to the squaring stage.
// Latency: first sq_start 1 cycle after the triggering pixel; >= 2 cycles per pair, then one DONE cycle.
// Backpressure: pix_ready low outside IDLE; waits on sq_q (HARRIS_SEQ_TIMEOUT_EN adds a 15-cycle watchdog and err).
module harris_neighbor_sequencer
    import harris_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int PIX_W = PIX_W_DEF,
    parameter int E_W   = E_W_DEF,
    parameter int CW    = $clog2(IMG_W),
    parameter int RW    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sof,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic             sq_start,
    output logic [PIX_W-1:0] sq_center,
    output logic [PIX_W-1:0] sq_target,
    output logic [E_W-1:0]   sq_e,
    input  logic             sq_q,
    input  logic [E_W-1:0]   sq_eout,
    output logic [E_W-1:0]   e_out,
    output logic             e_valid,
    output logic [CW-1:0]    e_col,
    output logic [RW-1:0]    e_row,
    output logic             err
);

    seq_state_t       state, state_nxt;
    logic [2:0]       k;
    logic [E_W-1:0]   e_acc;
    logic             rdy_en;
    logic [CW-1:0]    col, cur_col;
    logic [RW-1:0]    row, cur_row;
    logic [PIX_W-1:0] win [3][3];
    logic [PIX_W-1:0] lb0_q, lb1_q;
    logic [PIX_W-1:0] target;
    logic             accept, trigger;

    assign accept  = pix_valid && pix_ready;
    assign cur_col = sof ? '0 : col;
    assign cur_row = sof ? '0 : row;
    assign trigger = accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));

    // buf0 holds row-1, buf1 holds row-2; both read the old value at cur_col before it is overwritten.
    harris_line_buffer #(.IMG_W(IMG_W), .PIX_W(PIX_W), .CW(CW)) u_lb0 (
        .clk  (clk),
        .en   (accept),
        .col  (cur_col),
        .din  (pix_in),
        .dout (lb0_q)
    );

    harris_line_buffer #(.IMG_W(IMG_W), .PIX_W(PIX_W), .CW(CW)) u_lb1 (
        .clk  (clk),
        .en   (accept),
        .col  (cur_col),
        .din  (lb0_q),
        .dout (lb1_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb1_q;
            win[1][2] <= lb0_q;
            win[2][2] <= pix_in;
            if (cur_col == CW'(IMG_W - 1)) begin
                col <= '0;
                row <= (&cur_row) ? cur_row : cur_row + RW'(1);
            end else begin
                col <= cur_col + CW'(1);
                row <= cur_row;
            end
        end
    end

    always_comb begin
        target = win[1][1];
        case (nbr_t'(k))
            NW: target = win[0][0];
            N:  target = win[0][1];
            NE: target = win[0][2];
            W:  target = win[1][0];
            E:  target = win[1][2];
            SW: target = win[2][0];
            S:  target = win[2][1];
            SE: target = win[2][2];
            default: target = win[1][1];
        endcase
    end

`ifdef HARRIS_SEQ_TIMEOUT_EN
    logic [3:0] wd;
    logic       err_q, progress, stall_out;

    assign progress  = ((state == ISSUE) && sq_q) || ((state == GAP) && !sq_q);
    assign stall_out = ((state == ISSUE) || (state == GAP)) && !progress && (wd == 4'd14);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd    <= '0;
            err_q <= 1'b0;
        end else begin
            wd    <= (((state == ISSUE) || (state == GAP)) && !progress && !stall_out) ? wd + 4'd1 : 4'd0;
            err_q <= err_q | stall_out;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (trigger) state_nxt = ISSUE;
            ISSUE:   if (sq_q) state_nxt = GAP;
            GAP:     if (!sq_q) state_nxt = (k == 3'd7) ? DONE : ISSUE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
`ifdef HARRIS_SEQ_TIMEOUT_EN
        if (stall_out) state_nxt = IDLE;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            k      <= '0;
            e_acc  <= '0;
            rdy_en <= 1'b0;
            e_col  <= '0;
            e_row  <= '0;
        end else begin
            state  <= state_nxt;
            rdy_en <= 1'b1;
            if (state_nxt == IDLE) begin
                k <= '0;
            end else if ((state == GAP) && !sq_q) begin
                k <= k + 3'd1;
            end
            if ((state == ISSUE) && sq_q) begin
                e_acc <= sq_eout;
            end
            if (trigger) begin
                e_col <= cur_col - CW'(1);
                e_row <= cur_row - RW'(1);
            end
        end
    end

    // Outputs decode straight from state so reset drops sq_start without waiting for a clock.
    assign pix_ready = rdy_en && (state == IDLE);
    assign sq_start  = (state == ISSUE);
    assign sq_center = sq_start ? win[1][1] : '0;
    assign sq_target = sq_start ? target : '0;
    assign sq_e      = (sq_start && (k != 3'd0)) ? e_acc : '0;
    assign e_valid   = (state == DONE);
    assign e_out     = e_valid ? e_acc : '0;

endmodule

// File: tb/tb_harris_neighbor_sequencer.sv
// Bench for harris_neighbor_sequencer with IMG_W=4 and a behavioural squaring-stage model.
module tb_harris_neighbor_sequencer;

    localparam int IMG_W = 4;
    localparam int PIX_W = 8;
    localparam int E_W   = 14;
    localparam int CW    = 2;
    localparam int RW    = 16;

    typedef struct packed {
        logic [7:0]  c;
        logic [7:0]  t;
        logic [13:0] e;
    } pair_t;

    typedef struct packed {
        logic [13:0] e;
        logic [1:0]  col;
        logic [15:0] row;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sof = 1'b0;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix_in = '0;
    logic        sq_q = 1'b0;
    logic [13:0] sq_eout = '0;
    wire         pix_ready, sq_start, e_valid, err;
    wire  [7:0]  sq_center, sq_target;
    wire  [13:0] sq_e, e_out;
    wire  [1:0]  e_col;
    wire  [15:0] e_row;

    int total = 0;
    int bad = 0;
    int mode = 0;
    int dly = 1;
    bit stuck = 1'b0;

    pair_t obs_q[$];
    pair_t exp_pq[$];
    ev_t   ev_q[$];
    ev_t   exp_eq[$];
    logic [7:0] img [0:63];
    int dro[8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    int dco[8] = '{-1, 0, 1, -1, 1, -1, 0, 1};

    int   acc_cnt = 0, first_acc = -1, run = 0, min_run = 1000, unstable = 0, overlap = 0, dcnt = 0;
    bit   inwin = 1'b0;
    logic prev_start = 1'b0;
    pair_t held;

    always #5 clk = ~clk;

    harris_neighbor_sequencer #(.IMG_W(IMG_W), .PIX_W(PIX_W), .E_W(E_W), .CW(CW), .RW(RW)) dut (
        .clk       (clk),
        .rst       (rst),
        .sof       (sof),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .sq_start  (sq_start),
        .sq_center (sq_center),
        .sq_target (sq_target),
        .sq_e      (sq_e),
        .sq_q      (sq_q),
        .sq_eout   (sq_eout),
        .e_out     (e_out),
        .e_valid   (e_valid),
        .e_col     (e_col),
        .e_row     (e_row),
        .err       (err)
    );

    // Squaring stage: raises Q dly cycles after start, holds it until start drops.
    always @(posedge clk) begin
        if (!sq_start || stuck) begin
            dcnt <= 0;
            sq_q <= 1'b0;
        end else if (!sq_q) begin
            if (dcnt >= dly - 1) begin
                sq_q    <= 1'b1;
                sq_eout <= sq_e + ((mode != 0) ? {6'd0, sq_center ^ sq_target} : 14'd0) + 14'd1;
            end else begin
                dcnt <= dcnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        pair_t p;
        ev_t   ev;
        p.c = sq_center; p.t = sq_target; p.e = sq_e;
        if (sq_start && !prev_start) begin
            obs_q.push_back(p);
            held = p;
            run = 1;
            inwin = 1'b1;
            if (first_acc < 0) first_acc = acc_cnt;
        end else if (sq_start) begin
            run++;
            if (p !== held) unstable++;
        end else if (prev_start && run < min_run) begin
            min_run = run;
        end
        if (inwin && pix_ready) overlap++;
        if (e_valid) begin
            ev.e = e_out; ev.col = e_col; ev.row = e_row;
            ev_q.push_back(ev);
            inwin = 1'b0;
        end
        prev_start = sq_start;
    end

    task automatic clear_mon();
        obs_q.delete();
        ev_q.delete();
        acc_cnt = 0; first_acc = -1; min_run = 1000; unstable = 0; overlap = 0; inwin = 1'b0;
    endtask

    task automatic send(input logic [7:0] v, input bit s);
        int t;
        t = 0;
        @(negedge clk);
        while (!pix_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!pix_ready) begin
            total++; bad++;
            $display("FAIL send_ready pix_ready=%0b required=1", pix_ready);
        end
        pix_in = v; sof = s; pix_valid = 1'b1;
        @(posedge clk);
        #1;
        pix_valid = 1'b0; sof = 1'b0;
        acc_cnt++;
    endtask

    task automatic send_frame(input int n);
        for (int i = 0; i < n; i++) send(img[i], i == 0);
    endtask

    task automatic wait_events(input int n);
        int t;
        t = 0;
        while (ev_q.size() < n && t < 3000) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (ev_q.size() < n) begin
            bad++;
            $display("FAIL wait_events got=%0d required=%0d", ev_q.size(), n);
        end
        repeat (3) @(negedge clk);
    endtask

    // Reference: every interior pixel of the streamed frame yields 8 pairs in NW..SE order, energy chained.
    task automatic model_frame(input int n);
        int r, c, ci;
        logic [7:0]  cen, tg;
        logic [13:0] acc;
        pair_t p;
        ev_t   ev;
        exp_pq.delete();
        exp_eq.delete();
        for (int i = 0; i < n; i++) begin
            r = i / IMG_W;
            c = i % IMG_W;
            if (r >= 2 && c >= 2) begin
                ci  = (r - 1) * IMG_W + (c - 1);
                cen = img[ci];
                acc = '0;
                for (int k = 0; k < 8; k++) begin
                    tg = img[ci + dro[k] * IMG_W + dco[k]];
                    p.c = cen; p.t = tg; p.e = acc;
                    exp_pq.push_back(p);
                    acc = acc + {6'd0, cen ^ tg} + 14'd1;
                end
                ev.e = acc; ev.col = 2'(c - 1); ev.row = 16'(r - 1);
                exp_eq.push_back(ev);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (pix_ready !== 1'b0) begin
            bad++; $display("FAIL reset_ready got=%0b required=0", pix_ready);
        end
        total++;
        if ({sq_start, sq_center, sq_target, sq_e, e_out, e_valid, e_col, e_row, err} !== '0) begin
            bad++;
            $display("FAIL reset_outputs start=%0b c=%0d t=%0d e=%0d eo=%0d ev=%0b col=%0d row=%0d err=%0b required all 0",
                     sq_start, sq_center, sq_target, sq_e, e_out, e_valid, e_col, e_row, err);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (pix_ready !== 1'b1 || sq_start !== 1'b0) begin
            bad++; $display("FAIL reset_release ready=%0b start=%0b required 1/0", pix_ready, sq_start);
        end
    endtask

    task automatic test_constant();
        mode = 0; dly = 1;
        clear_mon();
        for (int i = 0; i < 12; i++) img[i] = 8'd10;
        send_frame(12);
        wait_events(2);
        total++;
        if (first_acc != 11) begin
            bad++; $display("FAIL const_first_start accepted=%0d required=11", first_acc);
        end
        total++;
        if (obs_q.size() != 16) begin
            bad++; $display("FAIL const_pair_count got=%0d required=16", obs_q.size());
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i].c !== 8'd10 || obs_q[i].t !== 8'd10 || obs_q[i].e !== 14'(i % 8)) begin
                bad++;
                $display("FAIL const_pair%0d c=%0d t=%0d e=%0d required 10/10/%0d", i, obs_q[i].c, obs_q[i].t, obs_q[i].e, i % 8);
            end
        end
        total++;
        if (ev_q[0].e !== 14'd8 || ev_q[0].col !== 2'd1 || ev_q[0].row !== 16'd1) begin
            bad++; $display("FAIL const_ev0 e=%0d col=%0d row=%0d required 8/1/1", ev_q[0].e, ev_q[0].col, ev_q[0].row);
        end
        total++;
        if (ev_q[1].e !== 14'd8 || ev_q[1].col !== 2'd2 || ev_q[1].row !== 16'd1) begin
            bad++; $display("FAIL const_ev1 e=%0d col=%0d row=%0d required 8/2/1", ev_q[1].e, ev_q[1].col, ev_q[1].row);
        end
    endtask

    task automatic test_pair_order();
        int tgt0[8] = '{0, 1, 2, 4, 6, 8, 9, 10};
        int tgt1[8] = '{1, 2, 3, 5, 7, 9, 10, 11};
        mode = 0; dly = 1;
        clear_mon();
        for (int i = 0; i < 12; i++) img[i] = 8'(i);
        send_frame(12);
        wait_events(2);
        for (int k = 0; k < 8; k++) begin
            total++;
            if (obs_q[k].c !== 8'd5 || obs_q[k].t !== 8'(tgt0[k])) begin
                bad++; $display("FAIL order_w0_k%0d c=%0d t=%0d required 5/%0d", k, obs_q[k].c, obs_q[k].t, tgt0[k]);
            end
            total++;
            if (obs_q[k + 8].c !== 8'd6 || obs_q[k + 8].t !== 8'(tgt1[k])) begin
                bad++; $display("FAIL order_w1_k%0d c=%0d t=%0d required 6/%0d", k, obs_q[k + 8].c, obs_q[k + 8].t, tgt1[k]);
            end
        end
        total++;
        if (ev_q[0].e !== 14'd8) begin
            bad++; $display("FAIL order_e got=%0d required=8", ev_q[0].e);
        end
    endtask

    task automatic test_random(input int frames, input int fixed_dly);
        for (int f = 0; f < frames; f++) begin
            mode = 1;
            dly = (fixed_dly > 0) ? fixed_dly : int'($urandom_range(1, 3));
            clear_mon();
            for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
            model_frame(16);
            send_frame(16);
            wait_events(exp_eq.size());
            total++;
            if (obs_q.size() != exp_pq.size() || ev_q.size() != exp_eq.size()) begin
                bad++; $display("FAIL rand_counts pairs=%0d events=%0d required %0d/%0d", obs_q.size(), ev_q.size(), exp_pq.size(), exp_eq.size());
            end
            for (int i = 0; i < exp_pq.size(); i++) begin
                total++;
                if (obs_q[i] !== exp_pq[i]) begin
                    bad++; $display("FAIL rand_pair%0d c=%0d t=%0d e=%0d required %0d/%0d/%0d", i, obs_q[i].c, obs_q[i].t, obs_q[i].e, exp_pq[i].c, exp_pq[i].t, exp_pq[i].e);
                end
            end
            for (int i = 0; i < exp_eq.size(); i++) begin
                total++;
                if (ev_q[i] !== exp_eq[i]) begin
                    bad++; $display("FAIL rand_ev%0d e=%0d col=%0d row=%0d required %0d/%0d/%0d", i, ev_q[i].e, ev_q[i].col, ev_q[i].row, exp_eq[i].e, exp_eq[i].col, exp_eq[i].row);
                end
            end
            total++;
            if (unstable != 0 || overlap != 0) begin
                bad++; $display("FAIL rand_stability unstable=%0d overlap=%0d required 0/0", unstable, overlap);
            end
            if (fixed_dly > 0) begin
                total++;
                if (min_run < fixed_dly) begin
                    bad++; $display("FAIL slow_hold start_cycles=%0d required>=%0d", min_run, fixed_dly);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int t;
        mode = 0; dly = 1;
        clear_mon();
        for (int i = 0; i < 12; i++) img[i] = 8'd10;
        send_frame(11);
        t = 0;
        while (obs_q.size() < 4 && t < 500) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (obs_q.size() < 4 || sq_start !== 1'b1) begin
            bad++; $display("FAIL midrst_reach pairs=%0d start=%0b required 4/1", obs_q.size(), sq_start);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (sq_start !== 1'b0) begin
            bad++; $display("FAIL midrst_async start=%0b required=0", sq_start);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (pix_ready !== 1'b1 || sq_start !== 1'b0) begin
            bad++; $display("FAIL midrst_idle ready=%0b start=%0b required 1/0", pix_ready, sq_start);
        end
        clear_mon();
        send_frame(12);
        wait_events(2);
        total++;
        if (ev_q[0].e !== 14'd8 || ev_q[0].col !== 2'd1 || ev_q[0].row !== 16'd1) begin
            bad++; $display("FAIL midrst_restream e=%0d col=%0d row=%0d required 8/1/1", ev_q[0].e, ev_q[0].col, ev_q[0].row);
        end
    endtask

    task automatic test_stuck();
        mode = 0; dly = 1; stuck = 1'b1;
        clear_mon();
        for (int i = 0; i < 12; i++) img[i] = 8'd10;
        send_frame(11);
        repeat (40) @(negedge clk);
`ifdef HARRIS_SEQ_TIMEOUT_EN
        total++;
        if (err !== 1'b1 || pix_ready !== 1'b1 || sq_start !== 1'b0) begin
            bad++; $display("FAIL timeout_state err=%0b ready=%0b start=%0b required 1/1/0", err, pix_ready, sq_start);
        end
`else
        total++;
        if (err !== 1'b0 || pix_ready !== 1'b0 || sq_start !== 1'b1) begin
            bad++; $display("FAIL stuck_wait err=%0b ready=%0b start=%0b required 0/0/1", err, pix_ready, sq_start);
        end
`endif
        total++;
        if (ev_q.size() != 0) begin
            bad++; $display("FAIL stuck_no_event events=%0d required=0", ev_q.size());
        end
        stuck = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (err !== 1'b0 || pix_ready !== 1'b1) begin
            bad++; $display("FAIL stuck_recover err=%0b ready=%0b required 0/1", err, pix_ready);
        end
    endtask

    initial begin
        test_reset();
        test_constant();
        test_pair_order();
        test_random(3, 0);
        test_random(1, 5);
        test_reset_mid();
        test_stuck();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
